// File: rtl/execute_unit.sv
// Curveball execute stage: forwarding muxes, WIDTH-bit ALU, iterative restoring divider, EX/MEM register.
// Optional single-cycle multiplier for opcode A is built only when EXECUTE_MUL_EN is defined.
module execute_unit #(
    parameter int WIDTH    = 16,
    parameter int FWD_SRCS = 2,
    localparam int SELW    = $clog2(FWD_SRCS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [3:0]                alu_op,
    input  logic [WIDTH-1:0]          data_a,
    input  logic [WIDTH-1:0]          data_b,
    input  logic [FWD_SRCS*WIDTH-1:0] fwd_data,
    input  logic [SELW-1:0]           fwd_sel_a,
    input  logic [SELW-1:0]           fwd_sel_b,
    input  logic                      zero_b,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          alu_out,
    output logic [WIDTH-1:0]          remainder,
    output logic [WIDTH-1:0]          data_a_out,
    output logic                      flag,
    output logic                      div_stall
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SLL = 4'h5;
    localparam logic [3:0] OP_SRL = 4'h6;
    localparam logic [3:0] OP_SRA = 4'h7;
    localparam logic [3:0] OP_SLT = 4'h8;
    localparam logic [3:0] OP_DIV = 4'h9;
`ifdef EXECUTE_MUL_EN
    localparam logic [3:0] OP_MUL = 4'hA;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    div_state_t state_q, state_d;

    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] final_res, final_rem;
    logic             div_start;

    logic [WIDTH-1:0] quo_q, rem_q, dsr_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH:0]   partial, diff;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic             quo_bit;

    // Select values beyond the last forwarding source fall back to the register-file operand.
    always_comb begin
        op_a = data_a;
        op_b = data_b;
        for (int k = 0; k < FWD_SRCS; k++) begin
            if (fwd_sel_a == SELW'(k + 1)) op_a = fwd_data[k*WIDTH +: WIDTH];
            if (fwd_sel_b == SELW'(k + 1)) op_b = fwd_data[k*WIDTH +: WIDTH];
        end
        if (zero_b) op_b = '0;
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD: alu_res = op_a + op_b;
            OP_SUB: alu_res = op_a - op_b;
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SLL: alu_res = op_a << op_b[SHW-1:0];
            OP_SRL: alu_res = op_a >> op_b[SHW-1:0];
            OP_SRA: alu_res = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef EXECUTE_MUL_EN
            OP_MUL: alu_res = op_a * op_b;
`endif
            default: alu_res = '0;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        partial  = {rem_q, quo_q[WIDTH-1]};
        diff     = partial - {1'b0, dsr_q};
        quo_bit  = (partial >= {1'b0, dsr_q});
        rem_next = quo_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], quo_bit};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Divider control; flush gates div_stall so decode is released in the same cycle.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        div_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && (alu_op == OP_DIV) && !flush) begin
                    div_start = 1'b1;
                    div_stall = 1'b1;
                    state_d   = (op_b == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                div_stall = !flush;
                if (flush)            state_d = IDLE;
                else if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                if (flush || !stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (div_start) begin
            dsr_q <= op_b;
            cnt_q <= SHW'(WIDTH - 1);
            if (op_b == '0) begin
                quo_q <= '1;
                rem_q <= op_a;
            end else begin
                quo_q <= op_a;
                rem_q <= '0;
            end
        end else if (state_q == BUSY) begin
            quo_q <= quo_next;
            rem_q <= rem_next;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign final_res = (state_q == DONE) ? quo_q : alu_res;
    assign final_rem = (state_q == DONE) ? rem_q : '0;

    // EX/MEM register: flush beats stall, stall beats the divider bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            alu_out    <= '0;
            remainder  <= '0;
            data_a_out <= '0;
            flag       <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            alu_out    <= '0;
            remainder  <= '0;
            data_a_out <= '0;
            flag       <= 1'b0;
        end else if (stall) begin
            out_valid  <= out_valid;
        end else if (div_stall) begin
            out_valid  <= 1'b0;
        end else begin
            out_valid  <= in_valid;
            alu_out    <= final_res;
            remainder  <= final_rem;
            data_a_out <= data_a;
            flag       <= (final_res == '0);
        end
    end

endmodule
